mmio_interconnect: RTL

MMIO_INTERCONNECT -- requirements
Module: mmio_interconnect

---
 rtl/mmio_interconnect.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mmio_interconnect.sv
// MMIO interconnect: one CPU master fanned out to NUM_SLAVES memory-mapped
// slaves. Address decode and write forwarding are combinational; read data
// returns through a READ_LATENCY-deep pipeline that remembers which slave
// (if any) owned each request. Unmapped accesses are logged in a small
// sticky fault block (flag, first address, saturating count).
module mmio_interconnect #(
  parameter int NUM_SLAVES   = 4,
  parameter int READ_LATENCY = 1,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
    {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK =
    {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      cpu_valid_in,
  input  logic [31:0]               cpu_addr_in,
  input  logic [31:0]               cpu_data_in,
  input  logic [3:0]                cpu_write_enable_in,
  output logic [31:0]               cpu_data_out,
  output logic [NUM_SLAVES*32-1:0]  slave_addr_out,
  output logic [NUM_SLAVES*32-1:0]  slave_data_out,
  output logic [NUM_SLAVES*4-1:0]   slave_write_enable_out,
  input  logic [NUM_SLAVES*32-1:0]  slave_data_in,
  input  logic                      fault_clear_in,
  output logic                      fault_out,
  output logic [31:0]               fault_addr_out,
  output logic [15:0]               fault_count_out
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic             addr_mapped;
  logic [IDX_W-1:0] win_idx;
  logic             unmapped_access;

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_mapped;
  logic [IDX_W-1:0]        pipe_idx [READ_LATENCY];

  // Address decode: scan high-to-low so the lowest matching index is kept last.
  always_comb begin
    addr_mapped = 1'b0;
    win_idx     = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((cpu_addr_in & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        addr_mapped = 1'b1;
        win_idx     = IDX_W'(i);
      end
    end
  end

  assign unmapped_access = cpu_valid_in && !addr_mapped;

  // Address offset and write data go to every slave; only strobes are gated.
  genvar g;
  generate
    for (g = 0; g < NUM_SLAVES; g++) begin : g_fwd
      assign slave_addr_out[g*32 +: 32] = cpu_addr_in & ~SLAVE_MASK[g*32 +: 32];
      assign slave_data_out[g*32 +: 32] = cpu_data_in;
    end
  endgenerate

  // Byte strobes reach only the winning slave of a valid request.
  always_comb begin
    slave_write_enable_out = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cpu_valid_in && addr_mapped && (win_idx == IDX_W'(i))) begin
        slave_write_enable_out[i*4 +: 4] = cpu_write_enable_in;
      end
    end
  end

  // Read-return tracking pipeline; reset flushes anything in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_valid  <= '0;
      pipe_mapped <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_idx[k] <= '0;
      end
    end else begin
      pipe_valid[0]  <= cpu_valid_in;
      pipe_mapped[0] <= addr_mapped;
      pipe_idx[0]    <= win_idx;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid[k]  <= pipe_valid[k-1];
        pipe_mapped[k] <= pipe_mapped[k-1];
        pipe_idx[k]    <= pipe_idx[k-1];
      end
    end
  end

  // Return mux at the pipeline tail; invalid or unmapped entries read as zero.
  always_comb begin
    cpu_data_out = '0;
    if (pipe_valid[READ_LATENCY-1] && pipe_mapped[READ_LATENCY-1]) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (pipe_idx[READ_LATENCY-1] == IDX_W'(i)) begin
          cpu_data_out = slave_data_in[i*32 +: 32];
        end
      end
    end
  end

  // Sticky fault log; a new fault in the clearing cycle starts a fresh record.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fault_out       <= 1'b0;
      fault_addr_out  <= '0;
      fault_count_out <= '0;
    end else if (unmapped_access) begin
      fault_out <= 1'b1;
      if (fault_clear_in) begin
        fault_count_out <= 16'd1;
        fault_addr_out  <= cpu_addr_in;
      end else begin
        if (fault_count_out != 16'hFFFF) begin
          fault_count_out <= fault_count_out + 16'd1;
        end
        if (!fault_out) begin
          fault_addr_out <= cpu_addr_in;
        end
      end
    end else if (fault_clear_in) begin
      fault_out       <= 1'b0;
      fault_addr_out  <= '0;
      fault_count_out <= '0;
    end
  end

endmodule
